sdrd_sector_reader: RTL
=======================

// Module: sdrd_sector_reader
// PURPOSE
//  Serves the FAT32 controller's sector requests (access address + datatype) by issuing CMD17 over the SPI byte engine.
//  Collects the 512-byte data block and packs it into sixteen 256-bit words, emitted with a valid strobe for the FAT entrance FIFO.
//  Sits between the FAT32 controller (request side) and the SPI byte engine (card side).
// PARAMETERS
//  BLOCK_ADDR   1     1: REQ_ADR is sent as-is (SDHC block address); 0: REQ_ADR<<9 sent (SDSC byte address)
//  R1_TIMEOUT   8     max 0xFF filler bytes polled before R1 (8..255)
//  TOK_TIMEOUT  2048  max bytes polled before data token 0xFE (8..65535)
// PORTS
//  CLK          in   1    system clock
//  RST          in   1    asynchronous active-high reset
//  SPI_INIT     in   1    card initialisation complete; no request accepted while 0
//  SPI_BUSY     in   1    byte engine busy; BYTE_START is legal only while 0
//  BYTE_START   out  1    1-cycle pulse: exchange BYTE_TX on SPI
//  BYTE_TX      out  8    byte to transmit
//  BYTE_DONE    in   1    1-cycle pulse: exchange finished, BYTE_RX valid
//  BYTE_RX      in   8    byte received during the exchange
//  REQ_VALID    in   1    sector request
//  REQ_ADR      in   32   sector address
//  REQ_TYPE     in   2    datatype tag, echoed on PRM_TYPE
//  REQ_READY    out  1    1 in IDLE with SPI_INIT=1; request accepted when REQ_VALID & REQ_READY
//  PRM          out  256  packed sector word; first card byte in [255:248]
//  PRM_VALID    out  1    1-cycle strobe per word, 16 per sector; no backpressure
//  PRM_LAST     out  1    high with the 16th PRM_VALID of a sector
//  PRM_TYPE     out  2    latched REQ_TYPE of the sector in progress
//  RD_ERR       out  1    sticky; R1!=0x00, R1 timeout, token timeout, or error token
// BEHAVIOUR
//  Reset: all outputs 0; BYTE_TX=0xFF; state IDLE; counters cleared. RST mid-sector aborts with no further PRM_VALID.
//  Accept: on REQ_VALID & REQ_READY, latch address and type, then go to CMD. Requests are ignored outside IDLE.
//  Byte issue rule: at most one exchange outstanding. Next BYTE_START no earlier than the cycle after BYTE_DONE, and only with SPI_BUSY=0.
//  FSM:
//   IDLE -> CMD on accept.
//   CMD: send 0x51, A[31:24], A[23:16], A[15:8], A[7:0], 0xFF (A = effective address). After the 6th BYTE_DONE -> R1WAIT.
//   R1WAIT: send 0xFF per poll. RX 0xFF -> poll again. RX 0x00 -> TOKWAIT. Other RX, or R1_TIMEOUT polls exhausted -> ERR.
//   TOKWAIT: send 0xFF per poll. RX 0xFE -> DATA. RX 0xFF -> poll again. RX with [7:4]==0 is an error token -> ERR. TOK_TIMEOUT exhausted -> ERR.
//   DATA: 512 exchanges of 0xFF. Each RX shifts into a 256-bit register (shift left 8, RX into [7:0]). Every 32nd byte: PRM and PRM_VALID assert the cycle after that BYTE_DONE. After byte 512 -> CRC.
//   CRC: 2 exchanges of 0xFF, bytes discarded, CRC not checked. Then one trailing 0xFF exchange (Ncr clock) -> IDLE.
//   ERR: set RD_ERR, send one trailing 0xFF -> IDLE. RD_ERR clears only on reset.
//  Counters: 9-bit byte counter in DATA (0..511, no wrap beyond). 5-bit intra-word index. Timeout counters saturate, never wrap.
//  SPI_INIT falling mid-operation is ignored until IDLE; REQ_READY then stays 0.
//  BLOCK_ADDR=0: A = {REQ_ADR[22:0], 9'b0}; upper bits are truncated.
//  Latency: PRM_LAST for a sector arrives no earlier than 6+1+1+512 exchanges after accept.
// TESTING
//  1 Req ADR=0x00002000, TYPE=2. Card: R1 0x00 after 1 filler, token after 3 fillers, data bytes 0..511 mod 256.
//    -> TX 51 00 00 20 00 FF; 16 PRM_VALID; word0 = 0x000102..1F; last word ends 0x..FF; PRM_LAST on the 16th; PRM_TYPE=2; RD_ERR=0.
//  2 BLOCK_ADDR=0, ADR=0x00000003 -> CMD bytes 51 00 00 06 00 FF.
//  3 Card returns R1=0x05 -> ERR; RD_ERR=1; no PRM_VALID; REQ_READY returns to 1 after the trailing byte.
//  4 Card returns 0xFF forever after R1 -> RD_ERR=1 after exactly TOK_TIMEOUT polls. Same check for R1 with R1_TIMEOUT.
//  5 SPI_BUSY held high 10 cycles after each BYTE_DONE -> no BYTE_START while busy; data identical to test 1.
//  6 Assert RST after PRM word 7 -> outputs zero at once; a new request afterwards completes normally with 16 words.

Source files
------------

// File: rtl/sdrd_sector_reader.sv
// rtl/sdrd_sector_reader.sv - CMD17 sector reader packing 512-byte SD blocks into 256-bit words
module sdrd_sector_reader #(
    parameter int BLOCK_ADDR  = 1,
    parameter int R1_TIMEOUT  = 8,
    parameter int TOK_TIMEOUT = 2048
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         SPI_INIT,
    input  logic         SPI_BUSY,
    output logic         BYTE_START,
    output logic [7:0]   BYTE_TX,
    input  logic         BYTE_DONE,
    input  logic [7:0]   BYTE_RX,
    input  logic         REQ_VALID,
    input  logic [31:0]  REQ_ADR,
    input  logic [1:0]   REQ_TYPE,
    output logic         REQ_READY,
    output logic [255:0] PRM,
    output logic         PRM_VALID,
    output logic         PRM_LAST,
    output logic [1:0]   PRM_TYPE,
    output logic         RD_ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_R1WAIT,
        S_TOKWAIT,
        S_DATA,
        S_CRC,
        S_ERR
    } state_t;

    localparam logic [15:0] R1_LAST  = 16'(R1_TIMEOUT - 1);
    localparam logic [15:0] TOK_LAST = 16'(TOK_TIMEOUT - 1);

    state_t         state, state_nx;
    logic           in_flight;
    logic           issue;
    logic           done;
    logic           accept;
    logic [7:0]     tx_nx;
    logic [8:0]     byte_cnt;
    logic [15:0]    poll_cnt;
    logic [31:0]    cmd_adr;
    logic [247:0]   shreg;
    logic [255:0]   shreg_nx;

    // A done pulse only counts while an exchange of ours is outstanding.
    assign done     = BYTE_DONE & in_flight;
    assign shreg_nx = {shreg, BYTE_RX};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        REQ_READY = 1'b0;
        accept    = 1'b0;
        tx_nx     = 8'hFF;
        case (state)
            S_IDLE: begin
                REQ_READY = SPI_INIT;
                if (REQ_VALID && SPI_INIT) begin
                    accept   = 1'b1;
                    state_nx = S_CMD;
                end
            end
            S_CMD: begin
                case (byte_cnt[2:0])
                    3'd0:    tx_nx = 8'h51;
                    3'd1:    tx_nx = cmd_adr[31:24];
                    3'd2:    tx_nx = cmd_adr[23:16];
                    3'd3:    tx_nx = cmd_adr[15:8];
                    3'd4:    tx_nx = cmd_adr[7:0];
                    default: tx_nx = 8'hFF;
                endcase
                if (done && byte_cnt == 9'd5) state_nx = S_R1WAIT;
            end
            S_R1WAIT: begin
                if (done) begin
                    if (BYTE_RX == 8'h00)
                        state_nx = S_TOKWAIT;
                    else if (BYTE_RX != 8'hFF || poll_cnt == R1_LAST)
                        state_nx = S_ERR;
                end
            end
            S_TOKWAIT: begin
                if (done) begin
                    if (BYTE_RX == 8'hFE)
                        state_nx = S_DATA;
                    else if (BYTE_RX[7:4] == 4'h0 || poll_cnt == TOK_LAST)
                        state_nx = S_ERR;
                end
            end
            S_DATA: begin
                if (done && byte_cnt == 9'd511) state_nx = S_CRC;
            end
            S_CRC: begin
                // two CRC bytes plus the trailing Ncr byte
                if (done && byte_cnt == 9'd2) state_nx = S_IDLE;
            end
            S_ERR: begin
                if (done) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        issue = (state != S_IDLE) && !in_flight && !BYTE_START && !SPI_BUSY;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BYTE_START <= 1'b0;
            BYTE_TX    <= 8'hFF;
            in_flight  <= 1'b0;
            byte_cnt   <= 9'd0;
            poll_cnt   <= 16'd0;
            cmd_adr    <= 32'd0;
            shreg      <= '0;
            PRM        <= '0;
            PRM_VALID  <= 1'b0;
            PRM_LAST   <= 1'b0;
            PRM_TYPE   <= 2'd0;
            RD_ERR     <= 1'b0;
        end else begin
            BYTE_START <= issue;
            BYTE_TX    <= issue ? tx_nx : 8'hFF;
            PRM_VALID  <= 1'b0;
            PRM_LAST   <= 1'b0;
            if (issue)
                in_flight <= 1'b1;
            else if (done)
                in_flight <= 1'b0;

            if (accept) begin
                cmd_adr  <= (BLOCK_ADDR != 0) ? REQ_ADR : {REQ_ADR[22:0], 9'd0};
                PRM_TYPE <= REQ_TYPE;
            end

            // Counters restart on every state change and saturate otherwise.
            if (state_nx != state) begin
                byte_cnt <= 9'd0;
                poll_cnt <= 16'd0;
            end else if (done) begin
                if (byte_cnt != 9'd511) byte_cnt <= byte_cnt + 9'd1;
                if (poll_cnt != 16'hFFFF) poll_cnt <= poll_cnt + 16'd1;
            end

            if (state == S_DATA && done) begin
                shreg <= shreg_nx[247:0];
                if (byte_cnt[4:0] == 5'd31) begin
                    PRM       <= shreg_nx;
                    PRM_VALID <= 1'b1;
                    PRM_LAST  <= (byte_cnt == 9'd511);
                end
            end

            if (state_nx == S_ERR && state != S_ERR) RD_ERR <= 1'b1;
        end
    end

endmodule
